// File: rtl/recorder_pkg.sv
// Shared constants for the recorder controller: FSM state encoding and
// default geometry of the clip memory.
package recorder_pkg;

  localparam int DEF_CLIP_AW  = 13;
  localparam int DEF_SAMPLE_W = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REC  = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

endpackage

// File: rtl/recorder_controller_edge.sv
// Rising-edge detector for a synchronized button level. The first clock after
// reset only captures the level, so a button held through reset never fires.
module edge_detect (
  input  logic clock_i,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;
  logic armed;

  always_ff @(posedge clock_i or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= 1'b1;
    end
  end

  assign rise = armed & level & ~prev;

endmodule

// File: rtl/recorder_controller.sv
// Two-clip audio recorder controller: records mic samples into a clip region
// of memory on each sample tick and plays them back up to the stored length.
module recorder_controller
  import recorder_pkg::*;
#(
  parameter int CLIP_AW  = DEF_CLIP_AW,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clock_i,
  input  logic                Reset,
  input  logic                Record,
  input  logic                Play,
  input  logic                Clip_no_r,
  input  logic                Clip_no_p,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] mic_sample,
  output logic [CLIP_AW:0]    mem_addr,
  output logic                mem_we,
  output logic [SAMPLE_W-1:0] mem_wdata,
  output logic                mem_re,
  output logic                recording,
  output logic                playing,
  output logic                done
);

  localparam int               CLIP_LEN = 2 ** CLIP_AW;
  localparam logic [CLIP_AW:0] LEN_FULL = CLIP_LEN[CLIP_AW:0];
  localparam logic [CLIP_AW-1:0] OFF_LAST = '1;

  logic [1:0]         state;
  logic               clip;
  logic [CLIP_AW-1:0] offset;
  logic [CLIP_AW:0]   len0;
  logic [CLIP_AW:0]   len1;
  logic               rec_rise;
  logic               play_rise;
  logic [CLIP_AW:0]   sel_len;
  logic               play_last;

  edge_detect u_rec_edge (
    .clock_i (clock_i),
    .reset   (Reset),
    .level   (Record),
    .rise    (rec_rise)
  );

  edge_detect u_play_edge (
    .clock_i (clock_i),
    .reset   (Reset),
    .level   (Play),
    .rise    (play_rise)
  );

  assign sel_len   = clip ? len1 : len0;
  assign play_last = ({1'b0, offset} == (sel_len - 1'b1));

  // Strobes default low each cycle; only the active state raises them.
  always_ff @(posedge clock_i or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      clip      <= 1'b0;
      offset    <= '0;
      len0      <= '0;
      len1      <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rec_rise) begin
            clip      <= Clip_no_r;
            offset    <= '0;
            state     <= ST_REC;
            recording <= 1'b1;
          end else if (play_rise) begin
            clip    <= Clip_no_p;
            offset  <= '0;
            state   <= ST_PLAY;
            playing <= 1'b1;
          end
        end
        ST_REC: begin
          if (!Record) begin
            state     <= ST_IDLE;
            recording <= 1'b0;
            done      <= 1'b1;
            if (clip) len1 <= {1'b0, offset};
            else      len0 <= {1'b0, offset};
          end else if (sample_tick) begin
            mem_we    <= 1'b1;
            mem_addr  <= {clip, offset};
            mem_wdata <= mic_sample;
            offset    <= offset + 1'b1;
            // Clip full: the last slot is being written right now.
            if (offset == OFF_LAST) begin
              state     <= ST_IDLE;
              recording <= 1'b0;
              done      <= 1'b1;
              if (clip) len1 <= LEN_FULL;
              else      len0 <= LEN_FULL;
            end
          end
        end
        ST_PLAY: begin
          if (sel_len == '0) begin
            state   <= ST_IDLE;
            playing <= 1'b0;
            done    <= 1'b1;
          end else if (sample_tick) begin
            mem_re   <= 1'b1;
            mem_addr <= {clip, offset};
            offset   <= offset + 1'b1;
            if (play_last) begin
              state   <= ST_IDLE;
              playing <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recorder_controller.sv
// Scoreboard bench for recorder_controller with CLIP_AW=3 (8-sample clips):
// stimulus pushes expected memory/done events, a negedge monitor pops them.
module tb_recorder_controller;

  localparam int AW = 3;
  localparam int SW = 12;

  localparam logic [1:0] EV_WR   = 2'd0;
  localparam logic [1:0] EV_RD   = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW:0]   addr;
    logic [SW-1:0] data;
  } ev_t;

  logic          clock_i = 1'b0;
  logic          Reset;
  logic          Record;
  logic          Play;
  logic          Clip_no_r;
  logic          Clip_no_p;
  logic          sample_tick;
  logic [SW-1:0] mic_sample;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [SW-1:0] mem_wdata;
  logic          mem_re;
  logic          recording;
  logic          playing;
  logic          done;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  recorder_controller #(.CLIP_AW(AW), .SAMPLE_W(SW)) dut (
    .clock_i     (clock_i),
    .Reset       (Reset),
    .Record      (Record),
    .Play        (Play),
    .Clip_no_r   (Clip_no_r),
    .Clip_no_p   (Clip_no_p),
    .sample_tick (sample_tick),
    .mic_sample  (mic_sample),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_re      (mem_re),
    .recording   (recording),
    .playing     (playing),
    .done        (done)
  );

  always #5 clock_i = ~clock_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic scoreEvent(input logic [1:0] kind, input logic [AW:0] addr, input logic [SW-1:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_event: got kind=%0d addr=%0d data=0x%0h expected nothing at %0t", kind, addr, data, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.addr !== addr || e.data !== data) begin
        failures++;
        $display("[TB] FAIL event: got kind=%0d addr=%0d data=0x%0h expected kind=%0d addr=%0d data=0x%0h at %0t",
                 kind, addr, data, e.kind, e.addr, e.data, $time);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the queue.
  always @(negedge clock_i) begin
    if (!Reset) begin
      if (mem_we || mem_re) checkOutput("we_re_exclusive", {31'b0, mem_we && mem_re}, 32'd0);
      if (mem_we) scoreEvent(EV_WR, mem_addr, mem_wdata);
      if (mem_re) scoreEvent(EV_RD, mem_addr, '0);
      if (done)   scoreEvent(EV_DONE, '0, '0);
    end
  end

  task automatic pushEv(input logic [1:0] kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = addr[AW:0];
    e.data = data[SW-1:0];
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic rec, input logic ply, input logic cr, input logic cp);
    Record    = rec;
    Play      = ply;
    Clip_no_r = cr;
    Clip_no_p = cp;
    @(posedge clock_i); #1;
  endtask

  task automatic applyTick(input int data);
    sample_tick = 1'b1;
    mic_sample  = data[SW-1:0];
    @(posedge clock_i); #1;
    sample_tick = 1'b0;
    mic_sample  = '0;
    @(posedge clock_i); #1;
  endtask

  task automatic waitDrain(input int max_cycles, input string name);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock_i); #1;
    end
    checkOutput(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic doReset();
    Reset = 1'b1;
    repeat (2) @(posedge clock_i);
    #1 Reset = 1'b0;
    @(posedge clock_i); #1;
  endtask

  initial begin
    Reset = 1'b1;
    Record = 0; Play = 0; Clip_no_r = 0; Clip_no_p = 0;
    sample_tick = 0; mic_sample = '0;
    repeat (2) @(posedge clock_i);
    #1;
    checkOutput("rst_addr", {28'b0, mem_addr}, 32'd0);
    checkOutput("rst_strobes", {26'b0, mem_we, mem_re, recording, playing, done, 1'b0}, 32'd0);
    checkOutput("rst_wdata", {20'b0, mem_wdata}, 32'd0);
    Reset = 1'b0;
    @(posedge clock_i); #1;

    // Play an empty clip straight after reset: done only, within 2 cycles.
    pushEv(EV_DONE, 0, 0);
    applyStimulus(0, 1, 0, 1);
    waitDrain(2, "empty_play_done");
    applyStimulus(0, 0, 0, 1);

    // Full recording of clip 1, then extra ticks must not write.
    applyStimulus(1, 0, 1, 0);
    checkOutput("rec_flag", {30'b0, recording, playing}, 32'd2);
    for (int i = 0; i < 8; i++) begin
      pushEv(EV_WR, 8 + i, 'h100 + i * 3);
      if (i == 7) pushEv(EV_DONE, 0, 0);
      applyTick('h100 + i * 3);
    end
    applyTick('h7ff);
    applyTick('h7fe);
    waitDrain(4, "full_rec_drain");
    checkOutput("full_rec_idle", {31'b0, recording}, 32'd0);
    applyStimulus(0, 0, 0, 0);

    // Short recording of clip 0 released after 3 ticks, then playback.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pushEv(EV_WR, i, 'hA50 + i);
      applyTick('hA50 + i);
    end
    pushEv(EV_DONE, 0, 0);
    applyStimulus(0, 0, 0, 0);
    waitDrain(4, "short_rec_drain");
    applyStimulus(0, 1, 0, 0);
    checkOutput("play_flag", {30'b0, recording, playing}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      pushEv(EV_RD, i, 0);
      if (i == 2) pushEv(EV_DONE, 0, 0);
      applyTick('h123);
    end
    applyTick('h123);
    waitDrain(4, "short_play_drain");
    applyStimulus(0, 0, 0, 0);

    // Simultaneous edges: Record wins; Play edge and clip change during REC ignored.
    applyStimulus(1, 1, 0, 1);
    checkOutput("both_edge_rec", {30'b0, recording, playing}, 32'd2);
    applyStimulus(1, 0, 1, 1);
    applyStimulus(1, 1, 1, 1);
    pushEv(EV_WR, 0, 'h3C3);
    applyTick('h3C3);
    pushEv(EV_WR, 1, 'h0F0);
    applyTick('h0F0);
    pushEv(EV_DONE, 0, 0);
    applyStimulus(0, 1, 1, 0);
    waitDrain(4, "both_rec_drain");
    applyStimulus(0, 0, 0, 0);

    // Play clip 0 (now length 2) with a Record edge mid-play.
    applyStimulus(0, 1, 0, 0);
    pushEv(EV_RD, 0, 0);
    applyTick('h001);
    applyStimulus(1, 1, 0, 1);
    checkOutput("rec_during_play", {30'b0, recording, playing}, 32'd1);
    pushEv(EV_RD, 1, 0);
    pushEv(EV_DONE, 0, 0);
    applyTick('h002);
    applyTick('h003);
    waitDrain(4, "play_len2_drain");
    applyStimulus(0, 0, 0, 0);

    // Clip 1 keeps its full length of 8.
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      pushEv(EV_RD, 8 + i, 0);
      if (i == 7) pushEv(EV_DONE, 0, 0);
      applyTick('h055);
    end
    waitDrain(4, "play_clip1_drain");
    applyStimulus(0, 0, 0, 0);

    // Reset in the middle of a recording aborts silently.
    applyStimulus(1, 0, 1, 0);
    pushEv(EV_WR, 8, 'h5A5);
    applyTick('h5A5);
    pushEv(EV_WR, 9, 'h6B6);
    applyTick('h6B6);
    waitDrain(2, "abort_writes");
    Reset = 1'b1;
    #1;
    checkOutput("abort_addr", {28'b0, mem_addr}, 32'd0);
    checkOutput("abort_wdata", {20'b0, mem_wdata}, 32'd0);
    checkOutput("abort_strobes", {27'b0, mem_we, mem_re, recording, playing, done}, 32'd0);
    repeat (2) @(posedge clock_i);
    #1 Reset = 1'b0;
    repeat (4) @(posedge clock_i);
    #1;
    checkOutput("held_record_idle", {30'b0, recording, playing}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    pushEv(EV_DONE, 0, 0);
    applyStimulus(0, 1, 0, 1);
    waitDrain(2, "len1_cleared");
    applyStimulus(0, 0, 0, 0);
    pushEv(EV_DONE, 0, 0);
    applyStimulus(0, 1, 0, 0);
    waitDrain(2, "len0_cleared");
    applyStimulus(0, 0, 0, 0);
    repeat (3) @(posedge clock_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
